// File: rtl/diff_clk_out_gen_if.sv
// ----------------------------------------------------------------------------
// diff_clk_out_gen_if
//   Bundles the control inputs and clock outputs of diff_clk_out_gen.
//
//   en          : request the output clock to run (level, sampled only in IDLE
//                 and at the end of a LOW half-period)
//   div         : half-period minus one, in clk cycles; sampled at period start
//   o / ob      : differential output pair (ob = ~o while running, 0 when idle)
//   odiv2       : toggles on every rising edge of o
//   running     : high while the generator is not idle
//   div_active  : divider value currently in use
//   state_dbg   : encoded FSM state (0 = IDLE, 1 = HIGH, 2 = LOW) for observers
//
//   Modports: master drives en/div and observes everything else;
//             slave is the generator itself.
// ----------------------------------------------------------------------------
interface diff_clk_out_gen_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 en;
    logic [DIV_WIDTH-1:0] div;
    logic                 o;
    logic                 ob;
    logic                 odiv2;
    logic                 running;
    logic [DIV_WIDTH-1:0] div_active;
    logic [1:0]           state_dbg;

    modport master (
        output en,
        output div,
        input  o,
        input  ob,
        input  odiv2,
        input  running,
        input  div_active,
        input  state_dbg
    );

    modport slave (
        input  en,
        input  div,
        output o,
        output ob,
        output odiv2,
        output running,
        output div_active,
        output state_dbg
    );
endinterface

// File: rtl/diff_clk_out_gen.sv
// ----------------------------------------------------------------------------
// diff_clk_out_gen
//   Generates a programmable-frequency differential clock pair (o / ob) and a
//   half-rate companion (odiv2) from the fabric clock. Each half period lasts
//   div_active+1 clk cycles; the divider is latched only when a new high
//   phase starts, so a running clock never produces a runt pulse. Start and
//   stop always happen on full half-period boundaries.
//
//   Ports:
//     clk  : fabric clock, all logic on its rising edge
//     rst  : asynchronous, active-high reset
//     bus  : diff_clk_out_gen_if.slave (en, div in; o, ob, odiv2, running,
//            div_active, state_dbg out)
//
//   All outputs come straight from flops; en and div only feed next-state
//   logic.
// ----------------------------------------------------------------------------
module diff_clk_out_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    diff_clk_out_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_active_q, div_active_d;
    logic                 o_q, o_d;
    logic                 ob_q, ob_d;
    logic                 odiv2_q, odiv2_d;
    logic                 running_q, running_d;

    // Compare happens before the increment, so cnt never needs to reach
    // div_active+1 and an all-ones divider cannot wrap.
    logic                 phase_done;
    assign phase_done = (cnt_q == div_active_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_active_q <= '0;
            o_q          <= 1'b0;
            ob_q         <= 1'b0;
            odiv2_q      <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            o_q          <= o_d;
            ob_q         <= ob_d;
            odiv2_q      <= odiv2_d;
            running_q    <= running_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        o_d          = o_q;
        ob_d         = ob_q;
        odiv2_d      = odiv2_q;
        running_d    = running_q;

        case (state_q)
            IDLE: begin
                o_d       = 1'b0;
                ob_d      = 1'b0;
                running_d = 1'b0;
                if (bus.en) begin
                    state_d      = HIGH;
                    div_active_d = bus.div;
                    cnt_d        = '0;
                    o_d          = 1'b1;
                    ob_d         = 1'b0;
                    odiv2_d      = ~odiv2_q;
                    running_d    = 1'b1;
                end
            end

            // en is deliberately not looked at here: a started high phase
            // always runs to completion.
            HIGH: begin
                if (phase_done) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    o_d     = 1'b0;
                    ob_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end

            // End of LOW is the only point where a running clock looks at en
            // and div, so a short en dropout inside LOW leaves no gap.
            LOW: begin
                if (phase_done) begin
                    cnt_d = '0;
                    if (bus.en) begin
                        state_d      = HIGH;
                        div_active_d = bus.div;
                        o_d          = 1'b1;
                        ob_d         = 1'b0;
                        odiv2_d      = ~odiv2_q;
                    end else begin
                        state_d   = IDLE;
                        o_d       = 1'b0;
                        ob_d      = 1'b0;
                        running_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                o_d       = 1'b0;
                ob_d      = 1'b0;
                running_d = 1'b0;
            end
        endcase
    end

    assign bus.o          = o_q;
    assign bus.ob         = ob_q;
    assign bus.odiv2      = odiv2_q;
    assign bus.running    = running_q;
    assign bus.div_active = div_active_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_diff_clk_out_gen.sv
// ----------------------------------------------------------------------------
// tb_diff_clk_out_gen
//   Directed bench for diff_clk_out_gen. Inputs change on the falling edge,
//   outputs are sampled on the falling edge. Expected waveforms are written
//   per cycle into exp_q as {o, ob, odiv2, running}; odiv2 is derived by
//   toggling on each expected rising edge of o.
// ----------------------------------------------------------------------------
module tb_diff_clk_out_gen;

    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    diff_clk_out_gen_if #(.DIV_WIDTH(DW)) bus ();

    diff_clk_out_gen #(.DIV_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [3:0] exp_q[$];
    logic       exp_odiv2;
    logic       prev_exp_o;
    int         checks;
    int         errors;

    function automatic void push_exp(input logic eo, input logic eob, input logic erun);
        if (eo && !prev_exp_o) exp_odiv2 = ~exp_odiv2;
        prev_exp_o = eo;
        exp_q.push_back({eo, eob, exp_odiv2, erun});
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0] got;
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.div = '0;
        repeat (3) @(negedge clk);
        got = {bus.o, bus.ob, bus.odiv2, bus.running};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held: got %b expected 0000", got);
        end
        checks++;
        if (bus.div_active !== 8'h00) begin
            errors++;
            $display("FAIL reset_div_active: got %h expected 00", bus.div_active);
        end
        rst        = 1'b0;
        exp_odiv2  = 1'b0;
        prev_exp_o = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got = {bus.o, bus.ob, bus.odiv2, bus.running};
            checks++;
            if (got !== 4'b0000 || bus.state_dbg !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b state %0d expected 0000 state 0",
                         k, got, bus.state_dbg);
            end
        end
    endtask

    task automatic test_div0();
        logic [3:0] got, exp;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push_exp(1'b1, 1'b0, 1'b1);
            else            push_exp(1'b0, 1'b1, 1'b1);
        end
        push_exp(1'b0, 1'b0, 1'b0);
        bus.div = 8'd0;
        bus.en  = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            got = {bus.o, bus.ob, bus.odiv2, bus.running};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL div0 cycle %0d: got %b expected %b", k, got, exp);
            end
            if (k == 7) bus.en = 1'b0;
        end
    endtask

    task automatic test_div_change();
        logic [3:0]    got, exp;
        logic [DW-1:0] exp_da;
        for (int k = 0; k < 16; k++) begin
            if (k < 3 || (k >= 6 && k < 11)) push_exp(1'b1, 1'b0, 1'b1);
            else                             push_exp(1'b0, 1'b1, 1'b1);
        end
        push_exp(1'b0, 1'b0, 1'b0);
        bus.div = 8'd2;
        bus.en  = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            got    = {bus.o, bus.ob, bus.odiv2, bus.running};
            exp    = exp_q.pop_front();
            exp_da = (k < 6) ? 8'd2 : 8'd4;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL div_change cycle %0d: got %b expected %b", k, got, exp);
            end
            checks++;
            if (bus.div_active !== exp_da) begin
                errors++;
                $display("FAIL div_change_active cycle %0d: got %0d expected %0d",
                         k, bus.div_active, exp_da);
            end
            if (k == 1)  bus.div = 8'd4;
            if (k == 15) bus.en  = 1'b0;
        end
    endtask

    task automatic test_en_drop();
        logic [3:0] got, exp;
        for (int k = 0; k < 10; k++) begin
            if (k < 4)      push_exp(1'b1, 1'b0, 1'b1);
            else if (k < 8) push_exp(1'b0, 1'b1, 1'b1);
            else            push_exp(1'b0, 1'b0, 1'b0);
        end
        bus.div = 8'd3;
        bus.en  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got = {bus.o, bus.ob, bus.odiv2, bus.running};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL en_drop cycle %0d: got %b expected %b", k, got, exp);
            end
            if (k == 1) bus.en = 1'b0;
        end
        // Restart from IDLE: o must rise one clk after en.
        for (int k = 0; k < 9; k++) begin
            if (k < 4)      push_exp(1'b1, 1'b0, 1'b1);
            else if (k < 8) push_exp(1'b0, 1'b1, 1'b1);
            else            push_exp(1'b0, 1'b0, 1'b0);
        end
        bus.en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            got = {bus.o, bus.ob, bus.odiv2, bus.running};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL en_restart cycle %0d: got %b expected %b", k, got, exp);
            end
            if (k == 0) bus.en = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, exp;
        for (int k = 0; k < 16; k++) begin
            if ((k / 4) % 2 == 0) push_exp(1'b1, 1'b0, 1'b1);
            else                  push_exp(1'b0, 1'b1, 1'b1);
        end
        push_exp(1'b0, 1'b0, 1'b0);
        bus.div = 8'd3;
        bus.en  = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            got = {bus.o, bus.ob, bus.odiv2, bus.running};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL en_pulse cycle %0d: got %b expected %b", k, got, exp);
            end
            if (k == 5)  bus.en = 1'b0;
            if (k == 6)  bus.en = 1'b1;
            if (k == 15) bus.en = 1'b0;
        end
    endtask

    task automatic test_max_div_reset();
        logic [3:0] got, exp;
        for (int k = 0; k < 100; k++) push_exp(1'b1, 1'b0, 1'b1);
        bus.div = 8'hFF;
        bus.en  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            got = {bus.o, bus.ob, bus.odiv2, bus.running};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL max_high cycle %0d: got %b expected %b", k, got, exp);
            end
        end
        // Asynchronous reset in the middle of the high phase.
        rst = 1'b1;
        #1;
        got = {bus.o, bus.ob, bus.odiv2, bus.running};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got %b expected 0000", got);
        end
        checks++;
        if (bus.div_active !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_div_active: got %h expected 00", bus.div_active);
        end
        exp_odiv2  = 1'b0;
        prev_exp_o = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 513; k++) begin
            if (k < 256)      push_exp(1'b1, 1'b0, 1'b1);
            else if (k < 512) push_exp(1'b0, 1'b1, 1'b1);
            else              push_exp(1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 513; k++) begin
            @(negedge clk);
            got = {bus.o, bus.ob, bus.odiv2, bus.running};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL max_restart cycle %0d: got %b expected %b", k, got, exp);
            end
            checks++;
            if (bus.div_active !== 8'hFF) begin
                errors++;
                $display("FAIL max_div_active cycle %0d: got %h expected ff", k, bus.div_active);
            end
            if (k == 511) bus.en = 1'b0;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        exp_odiv2  = 1'b0;
        prev_exp_o = 1'b0;
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.div    = '0;
        @(negedge clk);
        test_reset();
        test_div0();
        test_div_change();
        test_en_drop();
        test_back_to_back();
        test_max_div_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/diff_clk_out_gen.md
Name: diff_clk_out_gen

Overview:
- Generates a programmable-frequency differential clock pair (o / ob) plus a half-rate companion (odiv2) from the fabric clock.
- Drives board-level reference clock outputs, for example loopback refclk for a GT quad or an external PLL.
- It is the transmit-side counterpart of the differential refclk input buffer model.
- Start and stop are glitch-free. The divider value is applied only on period boundaries, so no runt pulses appear on o/ob.

Parameters:
DIV_WIDTH, 8, width of half-period divider input; half-period = div+1 clk cycles.

Ports:
clk  input  1  fabric clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  request output clock running; level-sensitive
div  input  DIV_WIDTH  half-period minus one, in clk cycles; sampled only at period start
o  output  1  generated clock, true leg
ob  output  1  generated clock, complement leg; always ~o when running, 0 when idle
odiv2  output  1  toggles on every rising edge of o (o/2)
running  output  1  high while FSM is not IDLE
div_active  output  DIV_WIDTH  divider value currently in use

Behaviour:
- Reset (async assert, sync release) forces the following values: state=IDLE, o=0, ob=0, odiv2=0, running=0, div_active=0, and the internal half-period counter cnt=0.
- All outputs are registered. No combinational path exists from en or div to any output.
- FSM states are IDLE, HIGH and LOW.
- IDLE:
  - o=0, ob=0, running=0.
  - When en=1 is sampled, the next cycle is HIGH: div_active<=div, cnt<=0, o=1, ob=0, odiv2 toggles, running=1.
  - Latency from en rising to o rising is 1 clk.
- HIGH:
  - cnt increments each cycle.
  - When cnt==div_active, go to LOW next cycle: o=0, ob=1, cnt<=0.
  - en is ignored mid-phase; a high phase always completes in full.
- LOW:
  - cnt increments each cycle.
  - When cnt==div_active and en=1, go to HIGH: div_active<=div (new value applied here only), cnt<=0, o=1, ob=0, odiv2 toggles.
  - When cnt==div_active and en=0, go to IDLE: o=0, ob=0, running=0.
- Timing:
  - Each half period is exactly div_active+1 clk cycles.
  - The period is 2*(div_active+1).
  - div=0 gives clk/2 with 50% duty.
- Changes to div while running have no effect until the next LOW→HIGH transition.
- Deasserting en during HIGH: HIGH completes, one full LOW half-period follows, then IDLE. The last high and low pulses are full width.
- If en is deasserted then reasserted before the end of LOW, the clock continues without a gap.
- odiv2 retains its value through IDLE; it is cleared only by rst.
- div at its all-ones maximum: cnt must not wrap before the compare. cnt is DIV_WIDTH bits wide, and the compare happens before increment.
- rst asserted mid-phase returns all outputs to reset values immediately (asynchronously). A truncated pulse is acceptable only under reset.

Test Plan:
1. rst=1 then released, en=0 for 10 cycles -> o=ob=odiv2=running=0 throughout.
2. div=0, en=1 held -> o rises 1 cycle after en; pattern 1,0,1,0; ob=~o; odiv2 toggles every 2 cycles; running=1.
3. div=2, en=1 -> o high 3 cycles, low 3 cycles, period 6. Change div to 4 mid-HIGH -> current period unchanged; next HIGH is 5 cycles; div_active=4 from that edge.
4. div=3 running; drop en on 2nd cycle of HIGH -> HIGH lasts 4 cycles total, LOW lasts 4 cycles, then IDLE: o=ob=0, running=0. Reassert en -> o rises after 1 cycle.
5. div=3; en pulsed low only during LOW phase (returns high before cnt==3) -> no gap; period remains 8 cycles.
6. div=8'hFF running; assert rst on 100th cycle of HIGH -> o=ob=odiv2=running=0 in the same cycle. After release with en=1 -> restart with a full 256-cycle HIGH.
